// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the default bus widths, the watchdog limit default, the FSM state
// encoding and the port index constants used by the arbiter, the
// round-robin picker and the bus interface.
package mem_arbiter_pkg;

    // Default data word width and byte address width.
    localparam int WORD_SIZE          = 16;
    localparam int ADDRESS_LEN        = 17;

    // Default number of BUSY cycles tolerated before the watchdog fires.
    localparam int TIMEOUT_CYCLES_DEF = 200;

    // Watchdog counter width.
    localparam int WDOG_W             = 8;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // Port indices: port 0 is instruction fetch, port 1 is data load/store.
    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory
// controller.
//   slave  : the arbiter's view (requests and controller returns in,
//            memory command, done flags and status out)
//   master : the environment's view (requesters plus memory controller)
interface mem_arbiter_if #(
    parameter int WORD_SIZE   = mem_arbiter_pkg::WORD_SIZE,
    parameter int ADDRESS_LEN = mem_arbiter_pkg::ADDRESS_LEN
);
    // Requester side
    logic                   p0_req;
    logic                   p1_req;
    logic [ADDRESS_LEN-1:0] p0_address;
    logic [ADDRESS_LEN-1:0] p1_address;
    logic [WORD_SIZE-1:0]   p1_write_value;
    logic                   p1_write_enable;
    logic                   p0_done;
    logic                   p1_done;
    logic [WORD_SIZE-1:0]   read_value;

    // Memory controller side
    logic [ADDRESS_LEN-1:0] mem_address;
    logic [WORD_SIZE-1:0]   mem_write_value;
    logic                   mem_write_enable;
    logic                   mem_request;
    logic [WORD_SIZE-1:0]   mem_read_value;
    logic                   mem_request_complete;

    // Status
    logic                   busy;
    logic                   timeout;

    modport slave (
        input  p0_req, p1_req, p0_address, p1_address,
        input  p1_write_value, p1_write_enable,
        input  mem_read_value, mem_request_complete,
        output p0_done, p1_done, read_value,
        output mem_address, mem_write_value, mem_write_enable, mem_request,
        output busy, timeout
    );

    modport master (
        output p0_req, p1_req, p0_address, p1_address,
        output p1_write_value, p1_write_enable,
        output mem_read_value, mem_request_complete,
        input  p0_done, p1_done, read_value,
        input  mem_address, mem_write_value, mem_write_enable, mem_request,
        input  busy, timeout
    );
endinterface

// File: rtl/mem_arbiter_arb_rr_pick.sv
// Combinational two-way round-robin winner selection.
//   req[1:0]   : request levels, bit 0 = instruction fetch, bit 1 = data
//   last_grant : port granted most recently
//   grant      : selected port (only meaningful when some request is high)
module arb_rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    // A lone request wins outright; a tie goes to the port not served last.
    always_comb begin
        grant = PORT_IFETCH;
        case (req)
            2'b01:   grant = PORT_IFETCH;
            2'b10:   grant = PORT_DATA;
            2'b11:   grant = ~last_grant;
            default: grant = PORT_IFETCH;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (port 0) and data load/store
// (port 1) share one memory controller. Round-robin on ties, a watchdog
// that raises a sticky timeout if the controller never completes, and a
// global enable that freezes all state.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : when low, every register holds
//   bus        : requester, memory controller and status signals
module mem_arbiter #(
    parameter int WORD_SIZE      = mem_arbiter_pkg::WORD_SIZE,
    parameter int ADDRESS_LEN    = mem_arbiter_pkg::ADDRESS_LEN,
    parameter int TIMEOUT_CYCLES = mem_arbiter_pkg::TIMEOUT_CYCLES_DEF
) (
    input logic          clk,
    input logic          rst_n,
    input logic          ena,
    mem_arbiter_if.slave bus
);
    import mem_arbiter_pkg::*;

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

    state_e                 state_q,       state_d;
    logic                   last_grant_q,  last_grant_d;
    logic                   grant_q,       grant_d;
    logic [WDOG_W-1:0]      wdog_q,        wdog_d;
    logic                   mem_request_q, mem_request_d;
    logic                   mem_we_q,      mem_we_d;
    logic [ADDRESS_LEN-1:0] mem_addr_q,    mem_addr_d;
    logic [WORD_SIZE-1:0]   mem_wdata_q,   mem_wdata_d;
    logic [WORD_SIZE-1:0]   read_value_q,  read_value_d;
    logic                   p0_done_q,     p0_done_d;
    logic                   p1_done_q,     p1_done_d;
    logic                   busy_q,        busy_d;
    logic                   timeout_q,     timeout_d;

    logic                   pick_grant_s;
    logic                   granted_req_s;

    arb_rr_pick u_pick (
        .req        ({bus.p1_req, bus.p0_req}),
        .last_grant (last_grant_q),
        .grant      (pick_grant_s)
    );

    // Live request level of whichever port currently owns the transaction.
    assign granted_req_s = (grant_q == PORT_DATA) ? bus.p1_req : bus.p0_req;

    // Next-state and output logic; every register holds unless updated.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        wdog_d        = wdog_q;
        mem_request_d = mem_request_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        read_value_d  = read_value_q;
        p0_done_d     = p0_done_q;
        p1_done_d     = p1_done_q;
        timeout_d     = timeout_q;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    // A raised timeout blocks all further grants until reset.
                    if (!timeout_q && (bus.p0_req || bus.p1_req)) begin
                        grant_d       = pick_grant_s;
                        last_grant_d  = pick_grant_s;
                        wdog_d        = '0;
                        mem_request_d = 1'b1;
                        state_d       = BUSY;
                        if (pick_grant_s == PORT_DATA) begin
                            mem_addr_d  = bus.p1_address;
                            mem_wdata_d = bus.p1_write_value;
                            mem_we_d    = bus.p1_write_enable;
                        end else begin
                            // Instruction fetch never writes.
                            mem_addr_d  = bus.p0_address;
                            mem_wdata_d = '0;
                            mem_we_d    = 1'b0;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end

                BUSY: begin
                    // Completion takes priority over a watchdog expiring on the same cycle.
                    if (bus.mem_request_complete) begin
                        if (!mem_we_q) begin
                            read_value_d = bus.mem_read_value;
                        end else begin
                            read_value_d = read_value_q;
                        end
                        mem_request_d = 1'b0;
                        if (grant_q == PORT_DATA) begin
                            p1_done_d = 1'b1;
                        end else begin
                            p0_done_d = 1'b1;
                        end
                        state_d = RELEASE;
                    end else if ((wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1}) == WDOG_LIMIT) begin
                        wdog_d        = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
                        timeout_d     = 1'b1;
                        mem_request_d = 1'b0;
                        state_d       = IDLE;
                    end else begin
                        wdog_d = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
                    end
                end

                RELEASE: begin
                    // Wait for both the requester and the controller to let go,
                    // so the next request cannot see a stale complete.
                    if (!granted_req_s && !bus.mem_request_complete) begin
                        p0_done_d = 1'b0;
                        p1_done_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = RELEASE;
                    end
                end

                default: begin
                    state_d       = IDLE;
                    mem_request_d = 1'b0;
                    p0_done_d     = 1'b0;
                    p1_done_d     = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= PORT_DATA;
            grant_q       <= PORT_IFETCH;
            wdog_q        <= '0;
            mem_request_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            read_value_q  <= '0;
            p0_done_q     <= 1'b0;
            p1_done_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            wdog_q        <= wdog_d;
            mem_request_q <= mem_request_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            read_value_q  <= read_value_d;
            p0_done_q     <= p0_done_d;
            p1_done_q     <= p1_done_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.mem_request      = mem_request_q;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.mem_address      = mem_addr_q;
    assign bus.mem_write_value  = mem_wdata_q;
    assign bus.read_value       = read_value_q;
    assign bus.p0_done          = p0_done_q;
    assign bus.p1_done          = p1_done_q;
    assign bus.busy             = busy_q;
    assign bus.timeout          = timeout_q;

endmodule
